// File: rtl/reg_bank_pkg.sv
// Shared types and default sizes for the register bank and its clear sequencer.
package reg_bank_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_clr_fsm.sv
// Bulk-clear sequencer: walks ptr across every entry issuing a zero write,
// then pulses clr_done for one cycle.
module reg_bank_clr_fsm
    import reg_bank_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done,
    output logic [AW-1:0] ptr,
    output logic          clr_we
);

    localparam logic [AW-1:0] PTR_LAST = '1;

    clr_state_t    state, state_nxt;
    logic [AW-1:0] ptr_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        busy      = 1'b0;
        clr_done  = 1'b0;
        clr_we    = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                // Hold ptr on the last entry instead of wrapping.
                if (ptr == PTR_LAST) state_nxt = DONE;
                else                 ptr_nxt   = ptr + 1'b1;
            end
            DONE: begin
                clr_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule : reg_bank_clr_fsm

// File: rtl/reg_bank.sv
// Register bank: one write port, two combinational read ports, bulk clear.
// Define REG_BYPASS_EN to forward an accepted write straight to matching read ports.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] dat_in,
    output logic          wr_ready,
    input  logic [AW-1:0] rd_addrA,
    input  logic [AW-1:0] rd_addrB,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] core [DEPTH];
    logic [AW-1:0] ptr;
    logic          clr_we;
    logic          wr_fire;
    logic          wr_blocked;

    reg_bank_clr_fsm #(.AW(AW)) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .ptr      (ptr),
        .clr_we   (clr_we)
    );

    assign wr_ready   = ~busy;
    assign wr_fire    = wr_en & wr_ready;
    assign wr_blocked = (ZERO_R0 != 0) && (wr_addr == '0);

    // NOTE: the storage array is reset because reset must zero every entry
    // immediately; this makes it flops rather than an inferable RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) core[i] <= '0;
        end else if (clr_we) begin
            core[ptr] <= '0;
        end else if (wr_fire && !wr_blocked) begin
            core[wr_addr] <= dat_in;
        end
    end

    always_comb begin
        datA_out = core[rd_addrA];
        datB_out = core[rd_addrB];
`ifdef REG_BYPASS_EN
        if (wr_fire && (rd_addrA == wr_addr)) datA_out = dat_in;
        if (wr_fire && (rd_addrB == wr_addr)) datB_out = dat_in;
`endif
        // Hard-wired zero entry wins over stored data and forwarding.
        if ((ZERO_R0 != 0) && (rd_addrA == '0)) datA_out = '0;
        if ((ZERO_R0 != 0) && (rd_addrB == '0)) datB_out = '0;
    end

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus random traffic,
// compared against an array-based reference model for ZERO_R0=0 and ZERO_R0=1.
module tb_reg_bank;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] dat_in = '0;
    logic [AW-1:0] rd_addrA = '0;
    logic [AW-1:0] rd_addrB = '0;
    logic          clr_req = 1'b0;

    logic          wr_ready, busy, clr_done;
    logic [DW-1:0] datA_out, datB_out;
    logic          z_wr_ready, z_busy, z_clr_done;
    logic [DW-1:0] z_datA_out, z_datB_out;

    reg_bank #(.DW(DW), .AW(AW), .ZERO_R0(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .wr_ready(wr_ready), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .datA_out(datA_out), .datB_out(datB_out), .clr_req(clr_req),
        .busy(busy), .clr_done(clr_done)
    );

    reg_bank #(.DW(DW), .AW(AW), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .wr_ready(z_wr_ready), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .datA_out(z_datA_out), .datB_out(z_datB_out), .clr_req(clr_req),
        .busy(z_busy), .clr_done(z_clr_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mem[0] mirrors ZERO_R0=0, mem[1] mirrors ZERO_R0=1.
    // clr_pos counts cycles into a clear: 0 idle, 1..DEPTH clearing entry
    // clr_pos-1, DEPTH+1 the completion cycle.
    logic [DW-1:0] mem [2][DEPTH];
    int            clr_pos = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_busy();
        return (clr_pos >= 1) && (clr_pos <= DEPTH);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int z, input logic [AW-1:0] a);
        if (z != 0 && a == '0) return '0;
`ifdef REG_BYPASS_EN
        if (wr_en && !model_busy() && a == wr_addr) return dat_in;
`endif
        return mem[z][a];
    endfunction

    task automatic model_reset();
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < DEPTH; i++) mem[z][i] = '0;
        clr_pos = 0;
    endtask

    task automatic model_step();
        if (model_busy()) begin
            for (int z = 0; z < 2; z++) mem[z][clr_pos-1] = '0;
        end else if (wr_en) begin
            mem[0][wr_addr] = dat_in;
            if (wr_addr != '0) mem[1][wr_addr] = dat_in;
        end
        if (clr_pos == 0)              clr_pos = clr_req ? 1 : 0;
        else if (clr_pos == DEPTH + 1) clr_pos = 0;
        else                           clr_pos++;
    endtask

    task automatic check_outputs();
        check("wr_ready", wr_ready, !model_busy());
        check("busy", busy, model_busy());
        check("clr_done", clr_done, clr_pos == DEPTH + 1);
        check("z_busy", z_busy, model_busy());
        check("z_clr_done", z_clr_done, clr_pos == DEPTH + 1);
        check("datA", datA_out, exp_rd(0, rd_addrA));
        check("datB", datB_out, exp_rd(0, rd_addrB));
        check("z_datA", z_datA_out, exp_rd(1, rd_addrA));
        check("z_datB", z_datB_out, exp_rd(1, rd_addrB));
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        dat_in  = d;
        cycle();
        wr_en   = 1'b0;
    endtask

    initial begin
        int busy_n;
        int done_at;
        int done_seen;
        logic [DW-1:0] old7;

        // Reset state
        model_reset();
        #2;
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_clr_done", clr_done, 1'b0);
        check("rst_datA", datA_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Basic write then read
        rd_addrA = 4'd3;
        rd_addrB = 4'd4;
        write(4'd3, 8'hA5);
        #1;
        check("wr3_datA", datA_out, 8'hA5);
        check("wr3_datB", datB_out, 8'h00);
        cycle();

        // Entry 0 hard-wired to zero only in the ZERO_R0 instance
        rd_addrA = 4'd0;
        write(4'd0, 8'hFF);
        #1;
        check("r0_zero", z_datA_out, 8'h00);
        check("r0_plain", datA_out, 8'hFF);
        cycle();

        // Fill everything, then clear; a write attempted mid-clear is dropped
        for (int i = 0; i < DEPTH; i++) write(i[AW-1:0], DW'($urandom_range(1, 255)));
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        busy_n  = 0;
        done_at = 0;
        for (int n = 1; n <= 40 && done_at == 0; n++) begin
            #1;
            if (busy) busy_n++;
            if (clr_done) done_at = n;
            if (n == 3) begin
                wr_en   = 1'b1;
                wr_addr = 4'd5;
                dat_in  = 8'h3C;
                check("clr_wr_ready", wr_ready, 1'b0);
            end
            cycle();
            wr_en = 1'b0;
        end
        check("clr_busy_cycles", busy_n, 16);
        check("clr_done_cycle", done_at, 17);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addrA = i[AW-1:0];
            rd_addrB = i[AW-1:0];
            #1;
            check("cleared_A", datA_out, 8'h00);
            check("cleared_zB", z_datB_out, 8'h00);
        end
        cycle();

        // Same-cycle write and read of one address
        write(4'd7, 8'h11);
        old7     = 8'h11;
        rd_addrB = 4'd7;
        wr_en    = 1'b1;
        wr_addr  = 4'd7;
        dat_in   = 8'h5A;
        #1;
`ifdef REG_BYPASS_EN
        check("bypass_B", datB_out, 8'h5A);
`else
        check("bypass_B", datB_out, old7);
`endif
        cycle();
        wr_en = 1'b0;

        // Write and clear request together; clr_req then held to show no restart
        rd_addrA = 4'd9;
        wr_en    = 1'b1;
        wr_addr  = 4'd9;
        dat_in   = 8'h77;
        clr_req  = 1'b1;
        cycle();
        wr_en = 1'b0;
        #1;
        check("wrclr_datA", datA_out, 8'h77);
        check("wrclr_busy", busy, 1'b1);
        for (int n = 0; n < 10; n++) cycle();
        clr_req = 1'b0;
        for (int n = 0; n < 12; n++) cycle();
        #1;
        check("wrclr_final", datA_out, 8'h00);
        cycle();

        // Reset mid-clear at ptr=6
        for (int i = 0; i < DEPTH; i++) write(i[AW-1:0], DW'($urandom_range(1, 255)));
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int n = 0; n < 6; n++) cycle();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_clr_done", clr_done, 1'b0);
        check("abort_wr_ready", wr_ready, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addrA = i[AW-1:0];
            rd_addrB = i[AW-1:0];
            #1;
            check("abort_A", datA_out, 8'h00);
            check("abort_zB", z_datB_out, 8'h00);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (clr_done) done_seen++;
            cycle();
        end
        check("abort_no_done", done_seen, 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, DEPTH - 1));
            dat_in   = DW'($urandom);
            rd_addrA = AW'($urandom_range(0, DEPTH - 1));
            rd_addrB = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
            clr_req  = ($urandom_range(0, 39) == 0);
            cycle();
        end
        wr_en   = 1'b0;
        clr_req = 1'b0;
        for (int n = 0; n < 20; n++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_bank
